// File: rtl/data_bus_arbiter.sv
// Two-master round-robin arbiter for the shared data bus, with optional bus lock
// bounded by MAX_LOCK cycles and a one-cycle registered response path.
module data_bus_arbiter #(
    parameter int MAX_LOCK = 16,
    parameter int CNT_W    = 5
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    input  logic        m0_lock_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    input  logic        m1_lock_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        s_req_o,
    output logic        s_we_o,
    output logic [3:0]  s_be_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_wdata_o,
    input  logic [31:0] s_rdata_i
);

    typedef enum logic [1:0] {IDLE, OWN_M0, OWN_M1} state_t;

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(MAX_LOCK - 1);

    state_t           state_q, state_d;
    logic             last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             rvalid_q;
    logic             resp_sel_q;
    logic             gnt0, gnt1;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        lock_cnt_d = lock_cnt_q;
        unique case (state_q)
            IDLE: begin
                // last_gnt_q==1 means master 1 went last, so master 0 wins a tie.
                if (m0_req_i && m1_req_i) begin
                    gnt0 = last_gnt_q;
                    gnt1 = !last_gnt_q;
                end else begin
                    gnt0 = m0_req_i;
                    gnt1 = m1_req_i;
                end
                if (gnt0) begin
                    last_gnt_d = 1'b0;
                    if (m0_lock_i) begin
                        state_d    = OWN_M0;
                        lock_cnt_d = '0;
                    end
                end else if (gnt1) begin
                    last_gnt_d = 1'b1;
                    if (m1_lock_i) begin
                        state_d    = OWN_M1;
                        lock_cnt_d = '0;
                    end
                end
            end
            OWN_M0: begin
                gnt0       = m0_req_i;
                lock_cnt_d = lock_cnt_q + 1'b1;
                if ((gnt0 && !m0_lock_i) || (lock_cnt_q == LOCK_LAST)) begin
                    state_d    = IDLE;
                    last_gnt_d = 1'b0;
                    lock_cnt_d = '0;
                end
            end
            OWN_M1: begin
                gnt1       = m1_req_i;
                lock_cnt_d = lock_cnt_q + 1'b1;
                if ((gnt1 && !m1_lock_i) || (lock_cnt_q == LOCK_LAST)) begin
                    state_d    = IDLE;
                    last_gnt_d = 1'b1;
                    lock_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Grants are suppressed combinationally while reset is asserted.
        if (!rst_n_i) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n_i) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            lock_cnt_q <= '0;
            rvalid_q   <= 1'b0;
            resp_sel_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid_q   <= gnt0 | gnt1;
            resp_sel_q <= gnt1;
        end
    end

    assign m0_gnt_o = gnt0;
    assign m1_gnt_o = gnt1;

    always_comb begin
        s_req_o   = gnt0 | gnt1;
        s_we_o    = 1'b0;
        s_be_o    = '0;
        s_addr_o  = '0;
        s_wdata_o = '0;
        if (gnt1) begin
            s_we_o    = m1_we_i;
            s_be_o    = m1_be_i;
            s_addr_o  = m1_addr_i;
            s_wdata_o = m1_wdata_i;
        end else if (gnt0) begin
            s_we_o    = m0_we_i;
            s_be_o    = m0_be_i;
            s_addr_o  = m0_addr_i;
            s_wdata_o = m0_wdata_i;
        end
    end

    assign m0_rvalid_o = rst_n_i && rvalid_q && !resp_sel_q;
    assign m1_rvalid_o = rst_n_i && rvalid_q && resp_sel_q;
    assign m0_rdata_o  = m0_rvalid_o ? s_rdata_i : 32'h0;
    assign m1_rdata_o  = m1_rvalid_o ? s_rdata_i : 32'h0;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Self-checking bench for data_bus_arbiter: directed scenarios followed by random
// traffic, all compared against a transaction-level ownership model.
module tb_data_bus_arbiter;

    localparam int MAX_LOCK = 16;
    localparam int CNT_W    = 5;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        m0_req_i, m0_we_i, m0_lock_i;
    logic [3:0]  m0_be_i;
    logic [31:0] m0_addr_i, m0_wdata_i;
    logic        m0_gnt_o, m0_rvalid_o;
    logic [31:0] m0_rdata_o;
    logic        m1_req_i, m1_we_i, m1_lock_i;
    logic [3:0]  m1_be_i;
    logic [31:0] m1_addr_i, m1_wdata_i;
    logic        m1_gnt_o, m1_rvalid_o;
    logic [31:0] m1_rdata_o;
    logic        s_req_o, s_we_o;
    logic [3:0]  s_be_o;
    logic [31:0] s_addr_o, s_wdata_o;
    logic [31:0] s_rdata_i;

    data_bus_arbiter #(.MAX_LOCK(MAX_LOCK), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i), .m0_addr_i(m0_addr_i),
        .m0_wdata_i(m0_wdata_i), .m0_lock_i(m0_lock_i), .m0_gnt_o(m0_gnt_o),
        .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i), .m1_addr_i(m1_addr_i),
        .m1_wdata_i(m1_wdata_i), .m1_lock_i(m1_lock_i), .m1_gnt_o(m1_gnt_o),
        .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_addr_o(s_addr_o),
        .s_wdata_o(s_wdata_o), .s_rdata_i(s_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the bus (-1 = nobody), how long it has been owned,
    // who went last, and which master (if any) is owed a response next cycle.
    int owner     = -1;
    int held      = 0;
    int last      = 1;
    bit pend      = 1'b0;
    int pend_who  = 0;

    logic [1:0]  obs_gnt;
    logic [1:0]  obs_rv;
    logic [31:0] obs_rd0;

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int model_winner();
        if (!rst_n_i) return -1;
        if (owner >= 0) return ((owner == 0) ? m0_req_i : m1_req_i) ? owner : -1;
        if (m0_req_i && m1_req_i) return 1 - last;
        if (m0_req_i) return 0;
        if (m1_req_i) return 1;
        return -1;
    endfunction

    task automatic set_idle();
        m0_req_i = 0; m0_we_i = 0; m0_lock_i = 0; m0_be_i = 4'hF; m0_addr_i = 32'h100; m0_wdata_i = 32'h1111_0000;
        m1_req_i = 0; m1_we_i = 1; m1_lock_i = 0; m1_be_i = 4'h3; m1_addr_i = 32'h200; m1_wdata_i = 32'h2222_0000;
    endtask

    // One clock: compare outputs mid-cycle against the model, then advance the model.
    task automatic cycle(input string tag);
        int          w;
        bit          wlock;
        logic [69:0] exp_bus;
        logic        ev0, ev1;
        #3;
        w       = model_winner();
        wlock   = (w == 0) ? m0_lock_i : (w == 1) ? m1_lock_i : 1'b0;
        exp_bus = (w == 0) ? {1'b1, m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i} :
                  (w == 1) ? {1'b1, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i} : 70'h0;
        ev0     = rst_n_i && pend && (pend_who == 0);
        ev1     = rst_n_i && pend && (pend_who == 1);
        obs_gnt = {m1_gnt_o, m0_gnt_o};
        obs_rv  = {m1_rvalid_o, m0_rvalid_o};
        obs_rd0 = m0_rdata_o;
        check($sformatf("%s/gnt", tag), 128'(obs_gnt), 128'({w == 1, w == 0}));
        check($sformatf("%s/bus", tag), 128'({s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o}), 128'(exp_bus));
        check($sformatf("%s/resp", tag), 128'({m1_rvalid_o, m0_rvalid_o, m1_rdata_o, m0_rdata_o}),
              128'({ev1, ev0, ev1 ? s_rdata_i : 32'h0, ev0 ? s_rdata_i : 32'h0}));
        @(posedge clk_i);
        if (!rst_n_i) begin
            owner = -1; held = 0; last = 1; pend = 0; pend_who = 0;
        end else begin
            pend     = (w >= 0);
            pend_who = (w >= 0) ? w : 0;
            if (owner < 0) begin
                if (w >= 0) begin
                    last = w;
                    if (wlock) begin owner = w; held = 0; end
                end
            end else begin
                held++;
                if ((w == owner && !wlock) || held == MAX_LOCK) begin
                    last  = owner;
                    owner = -1;
                    held  = 0;
                end
            end
        end
        #1;
    endtask

    initial begin
        int waited;
        set_idle();
        rst_n_i   = 0;
        s_rdata_i = 32'h0;
        @(posedge clk_i);
        #1;

        // Reset held with both masters requesting.
        m0_req_i = 1; m1_req_i = 1;
        for (int i = 0; i < 3; i++) begin
            cycle("reset");
            check("reset_gnt", 128'(obs_gnt), 128'(2'b00));
            check("reset_rv", 128'(obs_rv), 128'(2'b00));
        end
        rst_n_i = 1;

        // Solo read by master 0.
        set_idle();
        m0_req_i = 1; m0_addr_i = 32'h10; m0_we_i = 0;
        cycle("solo_req");
        check("solo_gnt", 128'(obs_gnt), 128'(2'b01));
        set_idle();
        s_rdata_i = 32'hDEAD_BEEF;
        cycle("solo_resp");
        check("solo_rv", 128'(obs_rv), 128'(2'b01));
        check("solo_rdata", 128'(obs_rd0), 128'(32'hDEAD_BEEF));

        // Master 1 alone once, so master 0 wins the first tie.
        m1_req_i = 1;
        cycle("pre_tie");
        for (int i = 0; i < 6; i++) begin
            m0_req_i = 1; m1_req_i = 1; s_rdata_i = 32'hA000_0000 + i;
            cycle("tie");
            check("tie_alt", 128'(obs_gnt), 128'((i % 2 == 0) ? 2'b01 : 2'b10));
        end

        // Lock: master 0 alone once so master 1 wins the tie, then 3 locked + 1 release.
        set_idle();
        m0_req_i = 1;
        cycle("pre_lock");
        for (int i = 0; i < 4; i++) begin
            m0_req_i = 1; m1_req_i = 1; m1_lock_i = (i < 3); m1_addr_i = 32'h300 + i;
            cycle("lock");
            check("lock_m1", 128'(obs_gnt), 128'(2'b10));
        end
        m1_lock_i = 0;
        cycle("lock_after");
        check("lock_release", 128'(obs_gnt), 128'(2'b01));

        // Starvation bound: master 0 locks forever, master 1 keeps requesting.
        set_idle();
        m0_req_i = 1; m0_lock_i = 1;
        cycle("starve_first");
        check("starve_first_gnt", 128'(obs_gnt), 128'(2'b01));
        m1_req_i = 1;
        waited = 0;
        do begin
            waited++;
            cycle("starve");
        end while (obs_gnt != 2'b10 && waited < 20);
        check("starve_bound", 128'(waited <= MAX_LOCK + 1), 128'(1));
        check("starve_exact", 128'(waited), 128'(MAX_LOCK + 1));

        // Reset in the middle of a locked read by master 1.
        set_idle();
        m1_req_i = 1; m1_lock_i = 1;
        cycle("mid_lock");
        check("mid_lock_gnt", 128'(obs_gnt), 128'(2'b10));
        m1_req_i = 0;
        rst_n_i = 0;
        cycle("mid_rst");
        check("mid_rst_rv", 128'(obs_rv), 128'(2'b00));
        rst_n_i = 1;
        m0_req_i = 1; m1_req_i = 1; m0_lock_i = 0; m1_lock_i = 0;
        cycle("post_rst");
        check("post_rst_tie", 128'(obs_gnt), 128'(2'b01));
        check("post_rst_rv", 128'(obs_rv), 128'(2'b00));

        // Random traffic, including long locks and occasional resets.
        for (int i = 0; i < 600; i++) begin
            rst_n_i    = ($urandom_range(0, 79) != 0);
            m0_req_i   = ($urandom_range(0, 9) < 7);
            m1_req_i   = ($urandom_range(0, 9) < 7);
            m0_lock_i  = ($urandom_range(0, 3) != 0);
            m1_lock_i  = ($urandom_range(0, 3) != 0);
            m0_we_i    = $urandom_range(0, 1);
            m1_we_i    = $urandom_range(0, 1);
            m0_be_i    = 4'($urandom);
            m1_be_i    = 4'($urandom);
            m0_addr_i  = $urandom;
            m1_addr_i  = $urandom;
            m0_wdata_i = $urandom;
            m1_wdata_i = $urandom;
            s_rdata_i  = $urandom;
            cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
